gba_cart_bus: RTL

//  GBA cartridge-edge front end, directly upstream of the mux stage. Synchronises the GBA
//  bus strobes, latches/auto-increments the ROM address, and converts GBA ROM/SRAM accesses

---
 rtl/gba_cart_bus_pkg.sv | 42 ++++
 rtl/gba_cart_bus_sync.sv | 31 +++
 rtl/gba_cart_bus.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/gba_cart_bus_pkg.sv
// Shared types and constants for the GBA cartridge-edge front end.
package gba_cart_bus_pkg;

  localparam int unsigned HA_W        = 24;
  localparam int unsigned CART_ADDR_W = 26;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned REGION_BIT  = 25;

  localparam logic [1:0] DATA_WIDTH_8  = 2'b01;
  localparam logic [1:0] DATA_WIDTH_16 = 2'b10;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RD_WAIT  = 2'd1;
  localparam logic [1:0] S_RD_DRIVE = 2'd2;
  localparam logic [1:0] S_WR       = 2'd3;

  typedef struct packed {
    logic [CART_ADDR_W-1:0] addr;
    logic [1:0]             width;
    logic [DATA_W-1:0]      wr_data;
  } cart_req_t;

  // ROM byte address is the halfword address shifted left, region bit clear
  function automatic cart_req_t rom_req(input logic [HA_W-1:0] ha, input logic [DATA_W-1:0] data);
    cart_req_t r;
    r.addr    = {1'b0, ha, 1'b0};
    r.width   = DATA_WIDTH_16;
    r.wr_data = data;
    return r;
  endfunction

  function automatic cart_req_t sram_req(input logic [15:0] addr, input logic [7:0] data);
    cart_req_t r;
    r.addr             = '0;
    r.addr[15:0]       = addr;
    r.addr[REGION_BIT] = 1'b1;
    r.width            = DATA_WIDTH_8;
    r.wr_data          = {8'h00, data};
    return r;
  endfunction

endpackage

// File: rtl/gba_cart_bus_sync.sv
// Multi-flop synchroniser with rise/fall pulses taken from the last two stages of the chain.
module gba_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned W           = 1,
  parameter logic [W-1:0] RST_VAL    = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  // One extra history stage behind the synchronised output for edge detection
  logic [W-1:0] stg [SYNC_STAGES+1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i <= SYNC_STAGES; i++) stg[i] <= RST_VAL;
    end else begin
      stg[0] <= d;
      for (int unsigned i = 1; i <= SYNC_STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q    = stg[SYNC_STAGES-1];
  assign rise = stg[SYNC_STAGES-1] & ~stg[SYNC_STAGES];
  assign fall = ~stg[SYNC_STAGES-1] & stg[SYNC_STAGES];

endmodule

// File: rtl/gba_cart_bus.sv
// GBA cartridge-edge front end: synchronises GBA strobes, tracks the ROM address and
// turns ROM/SRAM accesses into cart_rd/cart_wr requests towards the mux.
module gba_cart_bus
  import gba_cart_bus_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MISS_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   gba_ncs,
  input  logic                   gba_ncs2,
  input  logic                   gba_nrd,
  input  logic                   gba_nwr,
  input  logic [15:0]            gba_ad_i,
  input  logic [7:0]             gba_a_i,
  output logic [15:0]            gba_ad_o,
  output logic                   gba_ad_oe,
  output logic [7:0]             gba_a_o,
  output logic                   gba_a_oe,
  output logic                   cart_rd,
  output logic                   cart_wr,
  output logic [CART_ADDR_W-1:0] cart_addr,
  output logic [1:0]             cart_data_width,
  output logic [DATA_W-1:0]      cart_wr_data,
  input  logic [DATA_W-1:0]      cart_rd_data,
  input  logic                   cart_rd_valid,
  output logic [MISS_CNT_W-1:0]  rd_miss_cnt
);

  // strobe vector order: {nwr, nrd, ncs2, ncs}
  logic [3:0]  strb_s, strb_rise, strb_fall;
  logic [23:0] bus_s, bus_rise, bus_fall;

  gba_sync #(.SYNC_STAGES(SYNC_STAGES), .W(4), .RST_VAL(4'hF)) u_strb_sync (
    .clk  (clk),
    .rst  (rst),
    .d    ({gba_nwr, gba_nrd, gba_ncs2, gba_ncs}),
    .q    (strb_s),
    .rise (strb_rise),
    .fall (strb_fall)
  );

  gba_sync #(.SYNC_STAGES(SYNC_STAGES), .W(24), .RST_VAL(24'h0)) u_bus_sync (
    .clk  (clk),
    .rst  (rst),
    .d    ({gba_a_i, gba_ad_i}),
    .q    (bus_s),
    .rise (bus_rise),
    .fall (bus_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{strb_fall[1], bus_rise, bus_fall};

  logic        ncs_s, ncs2_s;
  logic        ncs_fall, ncs_rise, ncs2_rise;
  logic        nrd_fall, nrd_rise, nwr_fall, nwr_rise;
  logic [15:0] ad_s;
  logic [7:0]  a_s;

  assign ncs_s     = strb_s[0];
  assign ncs2_s    = strb_s[1];
  assign ncs_fall  = strb_fall[0];
  assign ncs_rise  = strb_rise[0];
  assign ncs2_rise = strb_rise[1];
  assign nrd_fall  = strb_fall[2];
  assign nrd_rise  = strb_rise[2];
  assign nwr_fall  = strb_fall[3];
  assign nwr_rise  = strb_rise[3];
  assign ad_s      = bus_s[15:0];
  assign a_s       = bus_s[23:16];

  logic [HA_W-1:0] ha;
  logic [15:0]     sram_addr_q;

  // ROM halfword address: load on chip-select fall, advance after every strobe while selected
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ha <= '0;
    end else if (ncs_fall) begin
      ha <= {a_s, ad_s};
    end else if (!ncs_s && (nrd_rise || nwr_rise)) begin
      ha <= ha + HA_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_addr_q <= '0;
    end else if (!ncs2_s && (nrd_fall || nwr_fall)) begin
      sram_addr_q <= ad_s;
    end
  end

  logic [1:0]            state, state_nxt;
  cart_req_t             req_q, req_nxt;
  logic                  rom_q, rom_nxt;
  logic                  rd_nxt, wr_nxt;
  logic [15:0]           ad_o_nxt;
  logic [7:0]            a_o_nxt;
  logic                  ad_oe_nxt, a_oe_nxt;
  logic [MISS_CNT_W-1:0] miss_nxt;
  logic                  cs_low, rom_cs, acc_cs_rise;

  // ROM select wins whenever both chip selects are low
  assign rom_cs      = !ncs_s;
  assign cs_low      = !ncs_s || !ncs2_s;
  assign acc_cs_rise = rom_q ? ncs_rise : ncs2_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      req_q       <= '0;
      rom_q       <= 1'b0;
      cart_rd     <= 1'b0;
      cart_wr     <= 1'b0;
      gba_ad_o    <= '0;
      gba_ad_oe   <= 1'b0;
      gba_a_o     <= '0;
      gba_a_oe    <= 1'b0;
      rd_miss_cnt <= '0;
    end else begin
      state       <= state_nxt;
      req_q       <= req_nxt;
      rom_q       <= rom_nxt;
      cart_rd     <= rd_nxt;
      cart_wr     <= wr_nxt;
      gba_ad_o    <= ad_o_nxt;
      gba_ad_oe   <= ad_oe_nxt;
      gba_a_o     <= a_o_nxt;
      gba_a_oe    <= a_oe_nxt;
      rd_miss_cnt <= miss_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = req_q;
    rom_nxt   = rom_q;
    rd_nxt    = cart_rd;
    wr_nxt    = 1'b0;
    ad_o_nxt  = gba_ad_o;
    ad_oe_nxt = gba_ad_oe;
    a_o_nxt   = gba_a_o;
    a_oe_nxt  = gba_a_oe;
    miss_nxt  = rd_miss_cnt;
    case (state)
      S_IDLE: begin
        if (nrd_fall && cs_low) begin
          rom_nxt   = rom_cs;
          req_nxt   = rom_cs ? rom_req(ha, 16'h0) : sram_req(ad_s, 8'h00);
          rd_nxt    = 1'b1;
          state_nxt = S_RD_WAIT;
        end else if (nwr_rise && cs_low) begin
          rom_nxt   = rom_cs;
          req_nxt   = rom_cs ? rom_req(ha, ad_s) : sram_req(sram_addr_q, a_s);
          wr_nxt    = 1'b1;
          state_nxt = S_WR;
        end
      end
      S_RD_WAIT: begin
        // A strobe release before data arrives abandons the read; late valid is dropped
        if (nrd_rise || acc_cs_rise) begin
          rd_nxt    = 1'b0;
          state_nxt = S_IDLE;
          if (nrd_rise && (rd_miss_cnt != {MISS_CNT_W{1'b1}})) begin
            miss_nxt = rd_miss_cnt + MISS_CNT_W'(1);
          end
        end else if (cart_rd_valid) begin
          rd_nxt    = 1'b0;
          state_nxt = S_RD_DRIVE;
          if (rom_q) begin
            ad_o_nxt  = cart_rd_data;
            ad_oe_nxt = 1'b1;
          end else begin
            a_o_nxt  = cart_rd_data[7:0];
            a_oe_nxt = 1'b1;
          end
        end
      end
      S_RD_DRIVE: begin
        if (nrd_rise || acc_cs_rise) begin
          ad_oe_nxt = 1'b0;
          a_oe_nxt  = 1'b0;
          ad_o_nxt  = '0;
          a_o_nxt   = '0;
          state_nxt = S_IDLE;
        end
      end
      S_WR: begin
        req_nxt   = '0;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign cart_addr       = req_q.addr;
  assign cart_data_width = req_q.width;
  assign cart_wr_data    = req_q.wr_data;

endmodule
